// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared constants, FSM state encodings and helper function
//                for the 8N1 UART transceiver.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Frame geometry
    localparam int DATA_BITS = 8;
    localparam int BIT_CNT_W = $clog2(DATA_BITS);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_BITS - 1);

    // Transmitter states
    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_START = 2'd1;
    localparam logic [1:0] TX_DATA  = 2'd2;
    localparam logic [1:0] TX_STOP  = 2'd3;

    // Receiver states
    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    // Width of a counter that must hold values 0 .. clks-1
    function automatic int cnt_width(input int clks);
        return (clks < 2) ? 1 : $clog2(clks);
    endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_bit_timer
//  Description : Reloadable bit-period down counter. start_i loads a full bit
//                period; while en_i is high the counter runs and reloads
//                itself at zero, so it tiles consecutive bit periods with no
//                gap. mid_o fires CLKS_PER_BIT/2 cycles after each (re)load,
//                done_o fires on the last cycle of each bit period.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk_bus,
    input  logic rst,
    input  logic start_i,
    input  logic en_i,
    output logic mid_o,
    output logic done_o
);
    import uart_pkg::*;

    localparam int CNT_W = cnt_width(CLKS_PER_BIT);
    // Count runs LOAD_VAL .. 0, so the value k cycles after a load is
    // CLKS_PER_BIT-k; the mid strobe therefore sits at CLKS_PER_BIT - N/2.
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] MID_VAL  = CNT_W'(CLKS_PER_BIT - CLKS_PER_BIT / 2);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: explicit load wins, otherwise count down with auto-reload
    always_comb begin
        cnt_d = cnt_q;
        if (start_i) begin
            cnt_d = LOAD_VAL;
        end else if (en_i) begin
            if (cnt_q == '0) begin
                cnt_d = LOAD_VAL;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    // Counter register
    always_ff @(posedge clk_bus) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign mid_o  = en_i && (cnt_q == MID_VAL);
    assign done_o = en_i && (cnt_q == '0);

endmodule : uart_bit_timer
`default_nettype wire

// File: rtl/uart_txrx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_txrx
//  Description : Single-clock 8N1 UART transceiver. Independent transmitter
//                (request/idle handshake) and receiver (2-flop synchronizer,
//                mid-bit sampling, sticky data-available flag with clear).
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_txrx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk_bus,
    input  logic       rst,
    input  logic       tx_request,
    input  logic [7:0] data,
    output logic       idle,
    output logic       txd,
    input  logic       rxd_in,
    output logic [7:0] rx_data,
    output logic       data_available,
    input  logic       clear
);
    import uart_pkg::*;

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    logic [1:0]           tx_state_q, tx_state_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic [BIT_CNT_W-1:0] tx_bit_q,   tx_bit_d;
    logic                 txd_q,      txd_d;
    logic                 w_tx_accept;
    logic                 w_tx_done;
    logic                 w_unused_tx_mid;

    assign w_tx_accept = (tx_state_q == TX_IDLE) && tx_request;

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx_timer (
        .clk_bus (clk_bus),
        .rst     (rst),
        .start_i (w_tx_accept),
        .en_i    (tx_state_q != TX_IDLE),
        .mid_o   (w_unused_tx_mid),
        .done_o  (w_tx_done)
    );

    // TX next state: advance one bit at every end-of-bit strobe
    always_comb begin
        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_bit_d   = tx_bit_q;
        txd_d      = txd_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (tx_request) begin
                    tx_state_d = TX_START;
                    tx_shift_d = data;
                    txd_d      = 1'b0;
                end
            end
            TX_START: begin
                if (w_tx_done) begin
                    tx_state_d = TX_DATA;
                    txd_d      = tx_shift_q[0];
                    tx_shift_d = {1'b0, tx_shift_q[DATA_BITS-1:1]};
                    tx_bit_d   = '0;
                end
            end
            TX_DATA: begin
                if (w_tx_done) begin
                    if (tx_bit_q == LAST_BIT) begin
                        tx_state_d = TX_STOP;
                        txd_d      = 1'b1;
                    end else begin
                        txd_d      = tx_shift_q[0];
                        tx_shift_d = {1'b0, tx_shift_q[DATA_BITS-1:1]};
                        tx_bit_d   = tx_bit_q + BIT_CNT_W'(1);
                    end
                end
            end
            TX_STOP: begin
                if (w_tx_done) begin
                    tx_state_d = TX_IDLE;
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
                txd_d      = 1'b1;
            end
        endcase
    end

    // TX registers; txd is registered so the line never glitches
    always_ff @(posedge clk_bus) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_shift_q <= '0;
            tx_bit_q   <= '0;
            txd_q      <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_shift_q <= tx_shift_d;
            tx_bit_q   <= tx_bit_d;
            txd_q      <= txd_d;
        end
    end

    assign txd  = txd_q;
    assign idle = (tx_state_q == TX_IDLE);

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic                 rx_sync1_q, rx_sync2_q, rx_prev_q;
    logic                 w_rx_fall;
    logic [1:0]           rx_state_q, rx_state_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic [BIT_CNT_W-1:0] rx_bit_q,   rx_bit_d;
    logic [7:0]           rx_data_q,  rx_data_d;
    logic                 avail_q,    avail_d;
    logic                 w_rx_set;
    logic                 w_rx_mid;
    logic                 w_unused_rx_done;

    // Two-flop synchronizer plus one history flop for edge detection;
    // all reset to the idle-high line level so reset creates no false start
    always_ff @(posedge clk_bus) begin
        if (rst) begin
            rx_sync1_q <= 1'b1;
            rx_sync2_q <= 1'b1;
            rx_prev_q  <= 1'b1;
        end else begin
            rx_sync1_q <= rxd_in;
            rx_sync2_q <= rx_sync1_q;
            rx_prev_q  <= rx_sync2_q;
        end
    end

    assign w_rx_fall = rx_prev_q && !rx_sync2_q;

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx_timer (
        .clk_bus (clk_bus),
        .rst     (rst),
        .start_i ((rx_state_q == RX_IDLE) && w_rx_fall),
        .en_i    (rx_state_q != RX_IDLE),
        .mid_o   (w_rx_mid),
        .done_o  (w_unused_rx_done)
    );

    // RX next state: all decisions taken on the mid-bit strobe
    always_comb begin
        rx_state_d = rx_state_q;
        rx_shift_d = rx_shift_q;
        rx_bit_d   = rx_bit_q;
        rx_data_d  = rx_data_q;
        w_rx_set   = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (w_rx_fall) begin
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (w_rx_mid) begin
                    if (rx_sync2_q) begin
                        rx_state_d = RX_IDLE;   // glitch, not a start bit
                    end else begin
                        rx_state_d = RX_DATA;
                        rx_bit_d   = '0;
                    end
                end
            end
            RX_DATA: begin
                if (w_rx_mid) begin
                    rx_shift_d = {rx_sync2_q, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_bit_q == LAST_BIT) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + BIT_CNT_W'(1);
                    end
                end
            end
            RX_STOP: begin
                if (w_rx_mid) begin
                    // Leave right after the stop sample so the next start
                    // edge is caught; a low stop bit drops the byte silently
                    rx_state_d = RX_IDLE;
                    if (rx_sync2_q) begin
                        rx_data_d = rx_shift_q;
                        w_rx_set  = 1'b1;
                    end
                end
            end
            default: begin
                rx_state_d = RX_IDLE;
            end
        endcase
    end

    // A new byte takes priority over a simultaneous clear
    assign avail_d = w_rx_set || (avail_q && !clear);

    // RX registers
    always_ff @(posedge clk_bus) begin
        if (rst) begin
            rx_state_q <= RX_IDLE;
            rx_shift_q <= '0;
            rx_bit_q   <= '0;
            rx_data_q  <= '0;
            avail_q    <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_shift_q <= rx_shift_d;
            rx_bit_q   <= rx_bit_d;
            rx_data_q  <= rx_data_d;
            avail_q    <= avail_d;
        end
    end

    assign rx_data        = rx_data_q;
    assign data_available = avail_q;

endmodule : uart_txrx
`default_nettype wire

// File: tb/tb_uart_txrx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_txrx
//  Description : Directed self-checking bench for uart_txrx (CLKS_PER_BIT=16).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_txrx;

    localparam int N = 16;

    logic       clk_bus = 1'b0;
    logic       rst;
    logic       tx_request;
    logic [7:0] data;
    logic       idle;
    logic       txd;
    logic       rxd_in;
    logic [7:0] rx_data;
    logic       data_available;
    logic       clear;

    logic rxd_drv;
    logic loop_en;
    logic clr_tie;
    logic clear_drv;

    int vec  = 0;
    int miss = 0;

    always #5 clk_bus = ~clk_bus;

    assign rxd_in = loop_en ? txd : rxd_drv;
    assign clear  = clr_tie ? data_available : clear_drv;

    uart_txrx #(
        .CLKS_PER_BIT (N)
    ) dut (
        .clk_bus        (clk_bus),
        .rst            (rst),
        .tx_request     (tx_request),
        .data           (data),
        .idle           (idle),
        .txd            (txd),
        .rxd_in         (rxd_in),
        .rx_data        (rx_data),
        .data_available (data_available),
        .clear          (clear)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk_bus);
    endtask

    // Drive one serial frame on rxd_drv starting at the current falling edge.
    // clear_drv is raised for the single cycle whose index equals clr_at.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int clr_at);
        for (int k = 0; k < 10 * N; k++) begin
            int bi;
            bi = k / N;
            if (bi == 0)      rxd_drv = 1'b0;
            else if (bi == 9) rxd_drv = stop;
            else              rxd_drv = b[bi-1];
            clear_drv = (k == clr_at);
            @(negedge clk_bus);
        end
        rxd_drv   = 1'b1;
        clear_drv = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_drv = 1'b1;
        tick(1);
        clear_drv = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; tx_request = 1'b0; data = 8'h00;
        rxd_drv = 1'b1; loop_en = 1'b0; clr_tie = 1'b0; clear_drv = 1'b0;
        tick(3);
        vec++; if (txd !== 1'b1)            begin miss++; $display("FAIL reset_txd: got %b expected 1", txd); end
        vec++; if (idle !== 1'b1)           begin miss++; $display("FAIL reset_idle: got %b expected 1", idle); end
        vec++; if (data_available !== 1'b0) begin miss++; $display("FAIL reset_avail: got %b expected 0", data_available); end
        vec++; if (rx_data !== 8'h00)       begin miss++; $display("FAIL reset_rxdata: got %h expected 00", rx_data); end
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_tx_a5();
        logic [9:0] fr;
        fr = {1'b1, 8'hA5, 1'b0};
        vec++; if (idle !== 1'b1) begin miss++; $display("FAIL tx_pre_idle: got %b expected 1", idle); end
        data = 8'hA5; tx_request = 1'b1;
        tick(1);
        tx_request = 1'b0; data = 8'h00;
        for (int k = 0; k < 10 * N; k++) begin
            vec++; if (txd !== fr[k/N]) begin miss++; $display("FAIL tx_a5_bit cyc %0d: got %b expected %b", k, txd, fr[k/N]); end
            vec++; if (idle !== 1'b0)   begin miss++; $display("FAIL tx_a5_busy cyc %0d: got %b expected 0", k, idle); end
            tick(1);
        end
        vec++; if (idle !== 1'b1) begin miss++; $display("FAIL tx_a5_end_idle: got %b expected 1", idle); end
        vec++; if (txd !== 1'b1)  begin miss++; $display("FAIL tx_a5_end_txd: got %b expected 1", txd); end
        tick(2);
    endtask

    task automatic test_loopback();
        logic [7:0] bytes [4];
        int   acc;
        int   got;
        logic prev_idle;
        logic prev_av;
        bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h3C; bytes[3] = 8'h81;
        loop_en = 1'b1; clr_tie = 1'b1;
        acc = 0; got = 0;
        data = bytes[0]; tx_request = 1'b1;
        prev_idle = idle; prev_av = data_available;
        for (int c = 0; c < 900; c++) begin
            tick(1);
            if (prev_idle && !idle) begin
                acc++;
                if (acc < 4) data = bytes[acc];
                else         tx_request = 1'b0;
            end
            if (data_available) begin
                vec++;
                if (got >= 4) begin
                    miss++; $display("FAIL loop_extra_pulse: got %0d pulses expected 4", got + 1);
                end else if (rx_data !== bytes[got]) begin
                    miss++; $display("FAIL loop_byte %0d: got %h expected %h", got, rx_data, bytes[got]);
                end
                got++;
            end
            if (prev_av) begin
                vec++; if (data_available !== 1'b0) begin miss++; $display("FAIL loop_pulse_width: got %b expected 0", data_available); end
            end
            prev_idle = idle; prev_av = data_available;
        end
        vec++; if (got !== 4) begin miss++; $display("FAIL loop_pulse_count: got %0d expected 4", got); end
        vec++; if (acc !== 4) begin miss++; $display("FAIL loop_accept_count: got %0d expected 4", acc); end
        tx_request = 1'b0; loop_en = 1'b0; clr_tie = 1'b0;
        tick(2);
    endtask

    task automatic test_glitch();
        rxd_drv = 1'b0;
        tick(3);
        rxd_drv = 1'b1;
        tick(40);
        vec++; if (data_available !== 1'b0) begin miss++; $display("FAIL glitch_avail: got %b expected 0", data_available); end
        send_frame(8'h5A, 1'b1, -1);
        tick(4);
        vec++; if (data_available !== 1'b1) begin miss++; $display("FAIL glitch_next_avail: got %b expected 1", data_available); end
        vec++; if (rx_data !== 8'h5A)       begin miss++; $display("FAIL glitch_next_data: got %h expected 5a", rx_data); end
        pulse_clear();
        vec++; if (data_available !== 1'b0) begin miss++; $display("FAIL clear_flag: got %b expected 0", data_available); end
        tick(2);
    endtask

    task automatic test_framing();
        send_frame(8'h77, 1'b0, -1);
        tick(4);
        vec++; if (data_available !== 1'b0) begin miss++; $display("FAIL frame_err_avail: got %b expected 0", data_available); end
        vec++; if (rx_data !== 8'h5A)       begin miss++; $display("FAIL frame_err_data: got %h expected 5a", rx_data); end
        send_frame(8'h12, 1'b1, -1);
        tick(4);
        vec++; if (data_available !== 1'b1) begin miss++; $display("FAIL frame_good_avail: got %b expected 1", data_available); end
        vec++; if (rx_data !== 8'h12)       begin miss++; $display("FAIL frame_good_data: got %h expected 12", rx_data); end
        pulse_clear();
        tick(2);
    endtask

    task automatic test_overrun();
        send_frame(8'h11, 1'b1, -1);
        tick(4);
        vec++; if (data_available !== 1'b1) begin miss++; $display("FAIL ovr_first_avail: got %b expected 1", data_available); end
        vec++; if (rx_data !== 8'h11)       begin miss++; $display("FAIL ovr_first_data: got %h expected 11", rx_data); end
        send_frame(8'h22, 1'b1, -1);
        tick(4);
        vec++; if (data_available !== 1'b1) begin miss++; $display("FAIL ovr_second_avail: got %b expected 1", data_available); end
        vec++; if (rx_data !== 8'h22)       begin miss++; $display("FAIL ovr_second_data: got %h expected 22", rx_data); end
        // The flag is set on the edge closing cycle 154 of the frame; clear
        // is presented during that same cycle
        send_frame(8'h33, 1'b1, 154);
        vec++; if (data_available !== 1'b1) begin miss++; $display("FAIL set_beats_clear: got %b expected 1", data_available); end
        vec++; if (rx_data !== 8'h33)       begin miss++; $display("FAIL ovr_third_data: got %h expected 33", rx_data); end
        pulse_clear();
        vec++; if (data_available !== 1'b0) begin miss++; $display("FAIL ovr_clear: got %b expected 0", data_available); end
        tick(4);
    endtask

    task automatic test_reset_midframe();
        data = 8'hC3; tx_request = 1'b1;
        rxd_drv = 1'b0;
        tick(1);
        tx_request = 1'b0;
        tick(5);
        vec++; if (txd !== 1'b0)  begin miss++; $display("FAIL mid_pre_txd: got %b expected 0", txd); end
        vec++; if (idle !== 1'b0) begin miss++; $display("FAIL mid_pre_idle: got %b expected 0", idle); end
        rst = 1'b1;
        tick(1);
        vec++; if (txd !== 1'b1)            begin miss++; $display("FAIL mid_rst_txd: got %b expected 1", txd); end
        vec++; if (idle !== 1'b1)           begin miss++; $display("FAIL mid_rst_idle: got %b expected 1", idle); end
        vec++; if (data_available !== 1'b0) begin miss++; $display("FAIL mid_rst_avail: got %b expected 0", data_available); end
        vec++; if (rx_data !== 8'h00)       begin miss++; $display("FAIL mid_rst_rxdata: got %h expected 00", rx_data); end
        tick(2);
        rst = 1'b0; rxd_drv = 1'b1;
        tick(12 * N);
        vec++; if (data_available !== 1'b0) begin miss++; $display("FAIL mid_post_avail: got %b expected 0", data_available); end
        vec++; if (idle !== 1'b1)           begin miss++; $display("FAIL mid_post_idle: got %b expected 1", idle); end
        vec++; if (txd !== 1'b1)            begin miss++; $display("FAIL mid_post_txd: got %b expected 1", txd); end
    endtask

    initial begin
        test_reset();
        test_tx_a5();
        test_loopback();
        test_glitch();
        test_framing();
        test_overrun();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule : tb_uart_txrx
`default_nettype wire
